bldc_commutator: RTL and testbench
==================================

# bldc_commutator

Parametrised six-step BLDC commutation and PWM phase driver for one motor channel of the robot FPGA. Synchronises and debounces the three hall inputs, maps the hall code to a high-side/low-side switch pair, chops the high side with a duty-cycle PWM, and inserts per-phase dead time. Adds direction, brake, enable, hall-fault detection and a commutation step counter. Outputs drive the gate-driver inputs directly (active-low).

## Interface
- DUTY_W, 8: duty-cycle and PWM counter width
- FILTER_LEN, 4: cycles a synchronised hall code must be stable before acceptance (≥1)
- DEAD_TIME, 8: minimum cycles between one switch of a phase turning off and its complement turning on (0 = none)
- CNT_W, 16: step counter width
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = drive; 0 = coast (all switches off)
- direction  in  1  1 = forward table, 0 = reverse (high/low roles swapped)
- brake  in  1  1 = all low-side switches on, high sides off
- hall  in  3  raw hall sensors {C,B,A}, asynchronous
- duty_cycle  in  DUTY_W  high-side on-time per PWM period
- phase_h_inv  out  3  high-side gates {C,B,A}, 0 = on
- phase_l_inv  out  3  low-side gates {C,B,A}, 0 = on
- hall_fault  out  1  accepted hall code is 000 or 111
- step_count  out  CNT_W  count of accepted valid hall-code changes, wraps

## Operation
- Hall path: 2-flop synchroniser → stability counter; code accepted when unchanged for FILTER_LEN consecutive cycles. Accepted code resets to 000.
- Forward table (high+, low−): 101 A+B−, 100 A+C−, 110 B+C−, 010 B+A−, 011 C+A−, 001 C+B−. Reverse: same code, roles swapped (101 → B+A−). Third phase floats (both off).
- PWM: free-running DUTY_W counter, wraps 2^DUTY_W−1 → 0. duty_cycle latched when counter = all-ones; high side requested on while counter < latched duty. Duty 0 → never on; all-ones → on 2^DUTY_W−1 of 2^DUTY_W cycles. Low side of the active pair is on continuously (no chopping).
- States, priority top-down: IDLE (enable=0: all off, clears fault, step_count held), FAULT (hall_fault=1: all off), BRAKE (brake=1: all L on, all H off), RUN (table + PWM).
- Fault: set when an accepted code is 000/111. Without latch option, clears when a valid code is accepted.
- step_count increments by 1 when an accepted code is valid and differs from the previous accepted valid code; repeats and invalid codes do not count.
- Dead time, per phase: counter of cycles since complement last on, saturating at DEAD_TIME. A switch turns on only if requested and its counter ≥ DEAD_TIME; a switch already on stays on while requested. H and L of one phase are never simultaneously on, under any input sequence.
- Direction or brake change mid-run: applied next cycle; dead time alone guarantees shoot-through safety.

## Timing
- Reset: phase_h_inv=111, phase_l_inv=111, hall_fault=0, step_count=0, PWM counter 0, latched duty 0, dead-time counters saturated, state IDLE.
- Hall edge → accepted code: 2 + FILTER_LEN cycles; → gate outputs: +1 registered cycle; + up to DEAD_TIME if a switch turns on whose complement was on.
- Duty change takes effect at next PWM period start (counter 0).
- Enable 1→0 or fault: all gates off on next edge (no dead-time delay on turn-off).
- Hall toggling faster than FILTER_LEN: no acceptance, outputs unchanged.
- Reset asserted mid-operation: outputs off immediately (asynchronous).

## Configuration
- HALL_FAULT_LATCH_EN defined: hall_fault sticky once set; cleared only by reset_n or enable=0.
- Undefined: hall_fault follows the accepted code; driving resumes on next valid accepted code.

## Test plan
- Reset, enable=1, direction=1, duty=8'h80, hall sequence 001,011,010,110,100,101 each 10000 cycles → pairs C+B−, C+A−, B+A−, B+C−, A+C−, A+B−; H duty 128/256; step_count=6 (5 changes after the first accepted code plus the first valid acceptance).
- Same sequence with direction=0 → roles swapped each step; at every transition the incoming low side stays off ≥8 cycles after its phase's high side turns off; never H=L=0 on any phase.
- hall=001 glitch to 011 for 3 cycles (FILTER_LEN=4) → no commutation, step_count unchanged.
- hall=111 held 10 cycles → hall_fault=1, all gates 1 within 7 cycles; return to 001 → fault clears (macro undefined) or stays until enable pulsed low (macro defined).
- brake=1 while running at 101 → phase_l_inv=000 after dead time, phase_h_inv=111; brake=0 → resumes A+B−.
- duty 0 → phase_h_inv never 0; duty 8'hFF → high side off exactly 1 cycle per 256.

Source files
------------

// File: rtl/bldc_commutator.sv
// -----------------------------------------------------------------------------
// bldc_commutator
//
// Six-step BLDC commutation and PWM gate driver for one motor channel.
// The raw hall code is synchronised and filtered, mapped to a high-side /
// low-side switch pair, the high side is chopped by a free-running PWM, and
// every phase gets dead-time protection between its two switches.
//
// Optional feature macro: HALL_FAULT_LATCH_EN
//   defined   : hall_fault is sticky; cleared only by reset_n or enable=0.
//   undefined : hall_fault follows the last accepted hall code.
//
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   enable       in   1 = drive, 0 = coast (all switches off)
//   direction    in   1 = forward table, 0 = reverse (high/low swapped)
//   brake        in   1 = all low sides on, all high sides off
//   hall         in   raw hall sensors {C,B,A}, asynchronous
//   duty_cycle   in   high-side on-time per PWM period
//   phase_h_inv  out  high-side gates {C,B,A}, 0 = on
//   phase_l_inv  out  low-side gates {C,B,A}, 0 = on
//   hall_fault   out  accepted hall code is 000 or 111
//   step_count   out  accepted valid hall-code changes, wraps
//   fsm_state    out  registered operating state (0 idle, 1 fault,
//                     2 brake, 3 run) for observation
// -----------------------------------------------------------------------------
module bldc_commutator #(
  parameter int DUTY_W     = 8,
  parameter int FILTER_LEN = 4,
  parameter int DEAD_TIME  = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              direction,
  input  logic              brake,
  input  logic [2:0]        hall,
  input  logic [DUTY_W-1:0] duty_cycle,
  output logic [2:0]        phase_h_inv,
  output logic [2:0]        phase_l_inv,
  output logic              hall_fault,
  output logic [CNT_W-1:0]  step_count,
  output logic [1:0]        fsm_state
);

  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int DT_W   = (DEAD_TIME < 1) ? 1 : $clog2(DEAD_TIME + 1);

  localparam logic [FCNT_W-1:0] FLT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [FCNT_W-1:0] FLT_FULL = FCNT_W'(FILTER_LEN);
  localparam logic [DT_W-1:0]   DT_MAX   = DT_W'(DEAD_TIME);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FAULT = 2'd1,
    S_BRAKE = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t state_q, state_next;

  // ---------------------------------------------------------------------------
  // Hall synchroniser and stability filter
  // ---------------------------------------------------------------------------
  logic [2:0]        hall_s1, hall_s2;
  logic [FCNT_W-1:0] flt_cnt;
  logic              accept;
  logic              code_valid;
  logic [2:0]        acc_code;
  logic [2:0]        last_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hall_s1 <= 3'b000;
      hall_s2 <= 3'b000;
    end else begin
      hall_s1 <= hall;
      hall_s2 <= hall_s1;
    end
  end

  // flt_cnt counts consecutive cycles in which hall_s2 keeps its value.
  // It resets saturated so the reset code 000 is never re-accepted as a
  // fresh code (which would raise a spurious fault).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flt_cnt <= FLT_FULL;
    end else if (hall_s1 != hall_s2) begin
      flt_cnt <= '0;
    end else if (flt_cnt != FLT_FULL) begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // One-shot: fires on the cycle the code has been stable FILTER_LEN cycles.
  assign accept     = (hall_s1 == hall_s2) && (flt_cnt == FLT_LAST);
  assign code_valid = (hall_s2 != 3'b000) && (hall_s2 != 3'b111);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_code <= 3'b000;
    end else if (accept) begin
      acc_code <= hall_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // Hall fault
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hall_fault <= 1'b0;
    end else if (!enable) begin
      hall_fault <= 1'b0;
    end else if (accept) begin
`ifdef HALL_FAULT_LATCH_EN
      hall_fault <= hall_fault | ~code_valid;
`else
      hall_fault <= ~code_valid;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Step counter: counts accepted valid codes that differ from the previous
  // accepted valid code. Held while disabled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_count <= '0;
      last_valid <= 3'b000;
    end else if (enable && accept && code_valid && (hall_s2 != last_valid)) begin
      step_count <= step_count + 1'b1;
      last_valid <= hall_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM: free-running counter, duty sampled at the end of each period so a
  // new duty takes effect when the counter wraps to 0.
  // ---------------------------------------------------------------------------
  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] duty_lat;
  logic              pwm_on;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt  <= '0;
      duty_lat <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) begin
        duty_lat <= duty_cycle;
      end
    end
  end

  assign pwm_on = (pwm_cnt < duty_lat);

  // ---------------------------------------------------------------------------
  // Operating state. The gate registers are loaded from state_next so that
  // disable, fault and brake act on the very next edge; state_q is the
  // registered copy of the same decision.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = S_RUN;
    if (!enable) begin
      state_next = S_IDLE;
    end else if (hall_fault) begin
      state_next = S_FAULT;
    end else if (brake) begin
      state_next = S_BRAKE;
    end
  end

  assign fsm_state = state_q;

  // ---------------------------------------------------------------------------
  // Commutation table, one-hot phase masks {C,B,A}.
  // ---------------------------------------------------------------------------
  logic [2:0] fwd_h, fwd_l;
  logic [2:0] tab_h, tab_l;

  always_comb begin
    fwd_h = 3'b000;
    fwd_l = 3'b000;
    case (acc_code)
      3'b101:  begin fwd_h = 3'b001; fwd_l = 3'b010; end  // A+ B-
      3'b100:  begin fwd_h = 3'b001; fwd_l = 3'b100; end  // A+ C-
      3'b110:  begin fwd_h = 3'b010; fwd_l = 3'b100; end  // B+ C-
      3'b010:  begin fwd_h = 3'b010; fwd_l = 3'b001; end  // B+ A-
      3'b011:  begin fwd_h = 3'b100; fwd_l = 3'b001; end  // C+ A-
      3'b001:  begin fwd_h = 3'b100; fwd_l = 3'b010; end  // C+ B-
      default: begin fwd_h = 3'b000; fwd_l = 3'b000; end
    endcase
    if (direction) begin
      tab_h = fwd_h;
      tab_l = fwd_l;
    end else begin
      tab_h = fwd_l;
      tab_l = fwd_h;
    end
  end

  // ---------------------------------------------------------------------------
  // Switch requests from the operating state.
  // ---------------------------------------------------------------------------
  logic [2:0] req_h, req_l;

  always_comb begin
    req_h = 3'b000;
    req_l = 3'b000;
    case (state_next)
      S_BRAKE: req_l = 3'b111;
      S_RUN: begin
        req_h = tab_h & {3{pwm_on}};
        req_l = tab_l;
      end
      default: begin
        req_h = 3'b000;
        req_l = 3'b000;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Dead time. dt_h[p] counts cycles since the low side of phase p was last
  // on, dt_l[p] cycles since the high side was last on. A switch may turn on
  // only once its counter has saturated; one already on stays on while
  // requested. The extra cross terms make simultaneous H/L impossible even
  // with DEAD_TIME = 0.
  // ---------------------------------------------------------------------------
  logic [2:0]      h_on, l_on;
  logic [2:0]      h_next, l_next;
  logic [DT_W-1:0] dt_h [3];
  logic [DT_W-1:0] dt_l [3];

  always_comb begin
    h_next = 3'b000;
    l_next = 3'b000;
    for (int p = 0; p < 3; p++) begin
      h_next[p] = req_h[p] && (h_on[p] || (dt_h[p] >= DT_MAX)) && !l_on[p];
      l_next[p] = req_l[p] && (l_on[p] || (dt_l[p] >= DT_MAX)) &&
                  !h_on[p] && !h_next[p];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_on <= 3'b000;
      l_on <= 3'b000;
      for (int p = 0; p < 3; p++) begin
        dt_h[p] <= DT_MAX;
        dt_l[p] <= DT_MAX;
      end
    end else begin
      h_on <= h_next;
      l_on <= l_next;
      for (int p = 0; p < 3; p++) begin
        // Counters track the value being registered so they restart on the
        // same edge a switch turns on.
        if (l_next[p]) begin
          dt_h[p] <= '0;
        end else if (dt_h[p] < DT_MAX) begin
          dt_h[p] <= dt_h[p] + 1'b1;
        end
        if (h_next[p]) begin
          dt_l[p] <= '0;
        end else if (dt_l[p] < DT_MAX) begin
          dt_l[p] <= dt_l[p] + 1'b1;
        end
      end
    end
  end

  assign phase_h_inv = ~h_on;
  assign phase_l_inv = ~l_on;

endmodule

// File: tb/tb_bldc_commutator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bldc_commutator
//
// Bench for bldc_commutator with default parameters. Expected gate pairs and
// step counts come from a small table model and are queued when a hall code
// is driven, then popped and compared once the design has settled. A
// monitor watches every cycle for shoot-through and dead-time violations.
// -----------------------------------------------------------------------------
module tb_bldc_commutator;

  localparam int DUTY_W     = 8;
  localparam int FILTER_LEN = 4;
  localparam int DEAD_TIME  = 8;
  localparam int CNT_W      = 16;

  // clock / reset
  logic              clock = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              direction;
  logic              brake;
  logic [2:0]        hall;
  logic [DUTY_W-1:0] duty_cycle;
  logic [2:0]        phase_h_inv;
  logic [2:0]        phase_l_inv;
  logic              hall_fault;
  logic [CNT_W-1:0]  step_count;
  logic [1:0]        fsm_state;

  always #5 clock = ~clock;

  bldc_commutator #(
    .DUTY_W     (DUTY_W),
    .FILTER_LEN (FILTER_LEN),
    .DEAD_TIME  (DEAD_TIME),
    .CNT_W      (CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .direction   (direction),
    .brake       (brake),
    .hall        (hall),
    .duty_cycle  (duty_cycle),
    .phase_h_inv (phase_h_inv),
    .phase_l_inv (phase_l_inv),
    .hall_fault  (hall_fault),
    .step_count  (step_count),
    .fsm_state   (fsm_state)
  );

  int checks = 0;
  int passes = 0;

  // scoreboard: {h one-hot, l one-hot, step_count}
  logic [21:0]      exp_q[$];
  logic [CNT_W-1:0] model_step = '0;
  logic [2:0]       model_last = 3'b000;

  // ---------------------------------------------------------------------------
  // Safety monitor
  // ---------------------------------------------------------------------------
  int shoot_cnt = 0;
  int dt_viol   = 0;
  int since_h[3];
  int since_l[3];

  always @(negedge clock) begin
    logic hn, ln;
    if (!reset_n) begin
      for (int p = 0; p < 3; p++) begin
        since_h[p] = 1000;
        since_l[p] = 1000;
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        hn = !phase_h_inv[p];
        ln = !phase_l_inv[p];
        if (hn && ln) shoot_cnt++;
        if (ln && since_h[p] < DEAD_TIME) dt_viol++;
        if (hn && since_l[p] < DEAD_TIME) dt_viol++;
        since_h[p] = hn ? 0 : ((since_h[p] < 1000) ? since_h[p] + 1 : since_h[p]);
        since_l[p] = ln ? 0 : ((since_l[p] < 1000) ? since_l[p] + 1 : since_l[p]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Model and driver tasks
  // ---------------------------------------------------------------------------
  function automatic logic [5:0] model_pair(input logic [2:0] code, input logic dir);
    logic [2:0] h, l;
    h = 3'b000;
    l = 3'b000;
    case (code)
      3'b101: begin h = 3'b001; l = 3'b010; end
      3'b100: begin h = 3'b001; l = 3'b100; end
      3'b110: begin h = 3'b010; l = 3'b100; end
      3'b010: begin h = 3'b010; l = 3'b001; end
      3'b011: begin h = 3'b100; l = 3'b001; end
      3'b001: begin h = 3'b100; l = 3'b010; end
      default: begin h = 3'b000; l = 3'b000; end
    endcase
    return dir ? {h, l} : {l, h};
  endfunction

  function automatic int onehot_idx(input logic [2:0] v);
    return v[0] ? 0 : (v[1] ? 1 : 2);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drive a hall code and queue the expected result.
  task automatic drive_code(input logic [2:0] code, input logic dir);
    @(negedge clock);
    hall = code;
    if (code != 3'b000 && code != 3'b111 && code != model_last) begin
      model_step = model_step + 1'b1;
      model_last = code;
    end
    exp_q.push_back({model_pair(code, dir), model_step});
  endtask

  // Count high-side on cycles of phase p over one PWM period and any
  // cycles where another high side is on.
  task automatic measure_h(input int p, output int on_cnt, output int stray);
    on_cnt = 0;
    stray  = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      if (!phase_h_inv[p]) on_cnt++;
      for (int q = 0; q < 3; q++)
        if (q != p && !phase_h_inv[q]) stray++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n    = 1'b0;
    enable     = 1'b0;
    direction  = 1'b1;
    brake      = 1'b0;
    hall       = 3'b000;
    duty_cycle = 8'h80;
    cyc(3);
    checks++; if (phase_h_inv !== 3'b111) $display("FAIL reset_h got=%b exp=111", phase_h_inv); else passes++;
    checks++; if (phase_l_inv !== 3'b111) $display("FAIL reset_l got=%b exp=111", phase_l_inv); else passes++;
    @(negedge clock);
    reset_n = 1'b1;
    cyc(10);
    checks++; if (hall_fault !== 1'b0) $display("FAIL reset_fault got=%b exp=0", hall_fault); else passes++;
    checks++; if (step_count !== '0) $display("FAIL reset_step got=%0d exp=0", step_count); else passes++;
  endtask

  task automatic test_sequence(input logic dir);
    logic [2:0]  seq [6];
    logic [21:0] e;
    int on_cnt, stray;
    seq[0] = 3'b001; seq[1] = 3'b011; seq[2] = 3'b010;
    seq[3] = 3'b110; seq[4] = 3'b100; seq[5] = 3'b101;
    direction = dir;
    enable    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_code(seq[i], dir);
      cyc(300 + $urandom_range(0, 20));
      e = exp_q.pop_front();
      checks++;
      if (phase_l_inv !== ~e[18:16])
        $display("FAIL seq_low dir=%0d code=%b got=%b exp=%b", dir, seq[i], phase_l_inv, ~e[18:16]);
      else passes++;
      checks++;
      if (step_count !== e[15:0])
        $display("FAIL seq_step dir=%0d code=%b got=%0d exp=%0d", dir, seq[i], step_count, e[15:0]);
      else passes++;
      measure_h(onehot_idx(e[21:19]), on_cnt, stray);
      checks++;
      if (on_cnt !== 128)
        $display("FAIL seq_duty dir=%0d code=%b got=%0d exp=128", dir, seq[i], on_cnt);
      else passes++;
      checks++;
      if (stray !== 0)
        $display("FAIL seq_stray_h dir=%0d code=%b got=%0d exp=0", dir, seq[i], stray);
      else passes++;
    end
  endtask

  task automatic test_glitch();
    logic [21:0] e;
    int on_cnt, stray;
    direction = 1'b1;
    drive_code(3'b001, 1'b1);
    cyc(300);
    e = exp_q.pop_front();
    @(negedge clock);
    hall = 3'b011;
    cyc($urandom_range(1, FILTER_LEN - 1));
    hall = 3'b001;
    cyc(100);
    checks++; if (phase_l_inv !== ~e[18:16]) $display("FAIL glitch_low got=%b exp=%b", phase_l_inv, ~e[18:16]); else passes++;
    checks++; if (step_count !== e[15:0]) $display("FAIL glitch_step got=%0d exp=%0d", step_count, e[15:0]); else passes++;
    measure_h(onehot_idx(e[21:19]), on_cnt, stray);
    checks++; if (on_cnt !== 128) $display("FAIL glitch_duty got=%0d exp=128", on_cnt); else passes++;
  endtask

  task automatic test_fault();
    logic [21:0] e;
    @(negedge clock);
    hall = 3'b111;
    repeat (7) @(posedge clock);
    @(negedge clock);
    checks++; if (hall_fault !== 1'b1) $display("FAIL fault_set got=%b exp=1", hall_fault); else passes++;
    checks++; if (phase_h_inv !== 3'b111) $display("FAIL fault_h got=%b exp=111", phase_h_inv); else passes++;
    checks++; if (phase_l_inv !== 3'b111) $display("FAIL fault_l got=%b exp=111", phase_l_inv); else passes++;
    cyc(3);
    drive_code(3'b001, 1'b1);
`ifdef HALL_FAULT_LATCH_EN
    cyc(20);
    checks++; if (hall_fault !== 1'b1) $display("FAIL fault_sticky got=%b exp=1", hall_fault); else passes++;
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    checks++; if (hall_fault !== 1'b0) $display("FAIL fault_clear got=%b exp=0", hall_fault); else passes++;
`else
    repeat (7) @(posedge clock);
    @(negedge clock);
    checks++; if (hall_fault !== 1'b0) $display("FAIL fault_clear got=%b exp=0", hall_fault); else passes++;
`endif
    cyc(300);
    e = exp_q.pop_front();
    checks++; if (phase_l_inv !== ~e[18:16]) $display("FAIL fault_resume_low got=%b exp=%b", phase_l_inv, ~e[18:16]); else passes++;
    checks++; if (step_count !== e[15:0]) $display("FAIL fault_step got=%0d exp=%0d", step_count, e[15:0]); else passes++;
  endtask

  task automatic test_brake();
    logic [21:0] e;
    int on_cnt, stray;
    drive_code(3'b101, 1'b1);
    cyc(300);
    e = exp_q.pop_front();
    checks++; if (phase_l_inv !== ~e[18:16]) $display("FAIL brake_pre_low got=%b exp=%b", phase_l_inv, ~e[18:16]); else passes++;
    checks++; if (step_count !== e[15:0]) $display("FAIL brake_pre_step got=%0d exp=%0d", step_count, e[15:0]); else passes++;
    brake = 1'b1;
    cyc(DEAD_TIME + 12);
    checks++; if (phase_l_inv !== 3'b000) $display("FAIL brake_l got=%b exp=000", phase_l_inv); else passes++;
    checks++; if (phase_h_inv !== 3'b111) $display("FAIL brake_h got=%b exp=111", phase_h_inv); else passes++;
    brake = 1'b0;
    cyc(300);
    checks++; if (phase_l_inv !== ~e[18:16]) $display("FAIL brake_resume_low got=%b exp=%b", phase_l_inv, ~e[18:16]); else passes++;
    measure_h(onehot_idx(e[21:19]), on_cnt, stray);
    checks++; if (on_cnt !== 128) $display("FAIL brake_resume_duty got=%0d exp=128", on_cnt); else passes++;
  endtask

  task automatic test_duty_limits();
    int on_cnt, stray;
    duty_cycle = 8'h00;
    cyc(300);
    measure_h(0, on_cnt, stray);
    checks++; if (on_cnt !== 0) $display("FAIL duty_zero got=%0d exp=0", on_cnt); else passes++;
    duty_cycle = 8'hFF;
    cyc(300);
    measure_h(0, on_cnt, stray);
    checks++; if (on_cnt !== 255) $display("FAIL duty_full got=%0d exp=255", on_cnt); else passes++;
    duty_cycle = 8'h80;
    cyc(300);
  endtask

  task automatic test_disable();
    logic [CNT_W-1:0] held;
    held = model_step;
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    checks++; if (phase_h_inv !== 3'b111) $display("FAIL idle_h got=%b exp=111", phase_h_inv); else passes++;
    checks++; if (phase_l_inv !== 3'b111) $display("FAIL idle_l got=%b exp=111", phase_l_inv); else passes++;
    hall = 3'b100;
    cyc(20);
    checks++; if (step_count !== held) $display("FAIL idle_step got=%0d exp=%0d", step_count, held); else passes++;
    hall = 3'b101;
    cyc(20);
    enable = 1'b1;
    cyc(300);
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (phase_h_inv !== 3'b111) $display("FAIL areset_h got=%b exp=111", phase_h_inv); else passes++;
    checks++; if (phase_l_inv !== 3'b111) $display("FAIL areset_l got=%b exp=111", phase_l_inv); else passes++;
    checks++; if (step_count !== '0) $display("FAIL areset_step got=%0d exp=0", step_count); else passes++;
    #1 reset_n = 1'b1;
    cyc(5);
  endtask

  task automatic test_safety();
    checks++; if (shoot_cnt !== 0) $display("FAIL shoot_through got=%0d exp=0", shoot_cnt); else passes++;
    checks++; if (dt_viol !== 0) $display("FAIL dead_time got=%0d exp=0", dt_viol); else passes++;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_sequence(1'b1);
    test_sequence(1'b0);
    test_glitch();
    test_fault();
    test_brake();
    test_duty_limits();
    test_disable();
    test_safety();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
